logic_unit_arbiter: RTL and testbench

//  Shares one 16-bit bitwise logic unit (not16/and16/or16) between two requesters, e.g. ALU pre-stage and address masker.

---
 rtl/logic_unit_arbiter_pkg.sv | 29 ++
 rtl/logic_unit_arbiter_logic_unit16.sv | 39 +++
 rtl/logic_unit_arbiter.sv | 121 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-port 16-bit logic unit arbiter.
// Contents: logic-unit width, opcode and FSM state enums, and the captured
// operand bundle (opcode plus both operands) that the arbiter hands to the gate network.
package logic_unit_arbiter_pkg;

  localparam int unsigned LU_W = 16;

  // Opcode encoding shared with any other user of logic_unit16
  typedef enum logic [1:0] {
    LOP_AND  = 2'b00,
    LOP_OR   = 2'b01,
    LOP_NOT  = 2'b10,
    LOP_NAND = 2'b11
  } lop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Operands captured at grant time
  typedef struct packed {
    lop_e            op;
    logic [LU_W-1:0] a;
    logic [LU_W-1:0] b;
  } lu_req_t;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit16.sv
// logic_unit16: combinational 16-bit bitwise logic unit (AND / OR / NOT / NAND).
// Ports:
//   op_i  opcode (lop_e encoding)
//   a_i   operand a
//   b_i   operand b (ignored for NOT)
//   y_c   combinational result
module logic_unit16
  import logic_unit_arbiter_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic [LU_W-1:0] a_i,
  input  logic [LU_W-1:0] b_i,
  output logic [LU_W-1:0] y_c
);

  logic [LU_W-1:0] and_c;
  logic [LU_W-1:0] or_c;
  logic [LU_W-1:0] not_a_c;
  logic [LU_W-1:0] nand_c;

  // Gate network; NAND reuses the AND gate followed by the inverter
  assign and_c   = a_i & b_i;
  assign or_c    = a_i | b_i;
  assign not_a_c = ~a_i;
  assign nand_c  = ~and_c;

  // Opcode mux
  always_comb begin
    y_c = and_c;
    case (lop_e'(op_i))
      LOP_AND:  y_c = and_c;
      LOP_OR:   y_c = or_c;
      LOP_NOT:  y_c = not_a_c;
      LOP_NAND: y_c = nand_c;
      default:  y_c = and_c;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one logic_unit16 between two requesters using
// round-robin arbitration and a req/ack handshake. One operation in flight;
// IDLE -> EXEC -> RESP -> IDLE, ack pulses in RESP two cycles after grant.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req0/op0/a0/b0      requester 0 request, opcode, operands
//   ack0/out0           requester 0 completion pulse and held result
//   req1/op1/a1/b1      requester 1 request, opcode, operands
//   ack1/out1           requester 1 completion pulse and held result
//   busy                high while an operation occupies EXEC or RESP
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,   // only 16 is legal
  parameter bit          FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  output logic [WIDTH-1:0] out0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic [WIDTH-1:0] out1,
  output logic             busy
);

  state_e          state_q;
  logic            sel_q;
  logic            last_grant_q;
  lu_req_t         opnd_q;
  logic [LU_W-1:0] out0_q;
  logic [LU_W-1:0] out1_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            busy_q;

  logic            grant1_c;
  lu_req_t         win_c;
  logic [LU_W-1:0] lu_y_c;

  // Requester 1 wins if alone, or if both ask and requester 0 was served last
  assign grant1_c = req1 & (~req0 | ~last_grant_q);

  // Winner's operand bundle
  always_comb begin
    win_c = '{op: lop_e'(op0), a: a0, b: b0};
    if (grant1_c) begin
      win_c = '{op: lop_e'(op1), a: a1, b: b1};
    end
  end

  logic_unit16 u_lu (
    .op_i (opnd_q.op),
    .a_i  (opnd_q.a),
    .b_i  (opnd_q.b),
    .y_c  (lu_y_c)
  );

  // Arbiter FSM with operand and per-port result registers.
  // The selected out register is loaded on the EXEC edge so the result is
  // visible in the same cycle as the ack pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= ~FIRST_PRIO;
      opnd_q       <= '{op: LOP_AND, a: '0, b: '0};
      out0_q       <= '0;
      out1_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0 | req1) begin
            sel_q   <= grant1_c;
            opnd_q  <= win_c;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (sel_q) begin
            out1_q <= lu_y_c;
          end else begin
            out0_q <= lu_y_c;
          end
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          last_grant_q <= sel_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign out0 = out0_q;
  assign out1 = out1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter.
module tb_logic_unit_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [1:0]  op0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        ack0;
  logic [15:0] out0;
  logic        req1;
  logic [1:0]  op1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        ack1;
  logic [15:0] out1;
  logic        busy;

  int total;
  int bad;

  logic_unit_arbiter #(
    .WIDTH      (16),
    .FIRST_PRIO (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .op0   (op0),
    .a0    (a0),
    .b0    (b0),
    .ack0  (ack0),
    .out0  (out0),
    .req1  (req1),
    .op1   (op1),
    .a1    (a1),
    .b1    (b1),
    .ack1  (ack1),
    .out1  (out1),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One uncontested operation on a port; drop req in the ack cycle
  task automatic do_op(input bit port, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp,
                       input logic [15:0] other_exp);
    if (!port) begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
    tick();  // granted, now EXEC
    check("exec_busy", 16'(busy), 16'h1);
    check("exec_ack0", 16'(ack0), 16'h0);
    check("exec_ack1", 16'(ack1), 16'h0);
    tick();  // RESP
    check("resp_ack0", 16'(ack0), 16'(!port));
    check("resp_ack1", 16'(ack1), 16'(port));
    check("resp_out_sel", port ? out1 : out0, exp);
    check("resp_out_other", port ? out0 : out1, other_exp);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();  // back to IDLE
    check("idle_busy", 16'(busy), 16'h0);
    check("idle_ack0", 16'(ack0), 16'h0);
    check("idle_ack1", 16'(ack1), 16'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and five idle cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_rst_ack0", 16'(ack0), 16'h0);
      check("idle_rst_ack1", 16'(ack1), 16'h0);
      check("idle_rst_busy", 16'(busy), 16'h0);
    end
    check("rst_out0", out0, 16'h0000);
    check("rst_out1", out1, 16'h0000);

    // AND on port 0, NOT and NAND on port 1
    do_op(1'b0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000);
    do_op(1'b1, 2'b10, 16'h00FF, 16'h1234, 16'hFF00, 16'hF000);
    do_op(1'b1, 2'b11, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'hF000);

    // Operands are captured at grant
    req0 = 1'b1; op0 = 2'b01; a0 = 16'h1234; b0 = 16'h0001;
    tick();
    a0 = 16'h0000; op0 = 2'b10;
    tick();
    check("capture_ack0", 16'(ack0), 16'h1);
    check("capture_out0", out0, 16'h1235);
    req0 = 1'b0;
    tick();

    // Contention from a fresh reset: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; op0 = 2'b01; a0 = 16'h0001; b0 = 16'h0010;
    req1 = 1'b1; op1 = 2'b00; a1 = 16'hFFFF; b1 = 16'h00FF;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("rr_ack0", 16'(ack0), 16'((k == 2) || (k == 8)));
      check("rr_ack1", 16'(ack1), 16'((k == 5) || (k == 11)));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr_out0", out0, 16'h0011);
    check("rr_out1", out1, 16'h00FF);
    tick();

    // Reset during EXEC abandons the operation
    req0 = 1'b1; op0 = 2'b00; a0 = 16'hFFFF; b0 = 16'h1234;
    tick();
    check("pre_rst_busy", 16'(busy), 16'h1);
    reset = 1'b1;
    req0  = 1'b0;
    tick();
    check("midrst_ack0", 16'(ack0), 16'h0);
    check("midrst_ack1", 16'(ack1), 16'h0);
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_out0", out0, 16'h0000);
    check("midrst_out1", out1, 16'h0000);
    reset = 1'b0;
    tick();
    check("post_rst_ack0", 16'(ack0), 16'h0);
    do_op(1'b0, 2'b01, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
